arm_motion_sequencer: RTL
=========================

Name: arm_motion_sequencer

Overview:
Sits between the position sources (ROM position memory, accelerometer) and the servo PWM block. It chooses the target source, takes memory targets through a valid/ready handshake, and samples accelerometer targets on a periodic tick. It slews the commanded X/Y/Z positions toward the targets at a bounded rate, then settles before accepting new work. This replaces the hard mux in front of the PWM and display logic so that servos never jump.

Parameters:
POS_WIDTH, 10, width of every position/target bus
TICK_DIV, 500_000, clk cycles per motion tick (50 MHz -> 100 Hz)
STEP, 4, max position change per axis per tick
MIN_POS, 0, lower clamp for targets
MAX_POS, 180, upper clamp for targets
HOME_POS, 90, reset value of all positions and targets
SETTLE_TICKS, 10, ticks held in SETTLE after arrival
TIMEOUT_TICKS, 1000, SLEW watchdog limit (optional feature only)

Ports:
clk  in  1  system clock (MAX10_CLK1_50)
rst  in  1  asynchronous, active-low reset
select_source  in  1  0 = memory, 1 = accelerometer
mem_valid  in  1  memory target valid
mem_ready  out  1  sequencer accepts memory target
mem_x, mem_y, mem_z  in  POS_WIDTH  memory targets
accel_x, accel_y, accel_z  in  POS_WIDTH  accelerometer targets (free-running)
pos_x, pos_y, pos_z  out  POS_WIDTH  commanded positions to PWM/display
busy  out  1  high in SLEW or SETTLE
done  out  1  one-cycle pulse on SETTLE->IDLE
fault  out  1  sticky timeout flag (optional feature only, else tied 0)

Behaviour:
- Reset (rst=0, async): state=IDLE; pos_* = target_* = HOME_POS; tick counter=0; settle/timeout counters=0; done=0; fault=0.
- Tick: free-running counter 0..TICK_DIV-1. tick=1 for the single cycle in which the counter equals TICK_DIV-1, then the counter wraps to 0.
- Clamp: every latched target = min(max(in, MIN_POS), MAX_POS), compared unsigned.
- mem_ready = (state==IDLE) && (select_source==0). This is combinational from registered state.
- A memory transfer occurs only on a cycle where mem_valid && mem_ready.
- IDLE, memory mode: on a transfer, latch clamped mem_* into target_* and move to SLEW on the next cycle. Not tick-gated.
- IDLE, accel mode: on a tick, latch clamped accel_* into target_*. If any target differs from pos, move to SLEW; otherwise stay in IDLE.
- SLEW, per tick and per axis: diff = target - pos.
  - If |diff| <= STEP, pos = target.
  - Otherwise pos moves STEP toward target.
  - The step uses the target value held before this tick.
  - Accel mode: the same tick also resamples target_* from clamped accel_*.
  - Memory mode: target_* is locked in SLEW.
- SLEW -> SETTLE: on any cycle in which pos == target on all three axes. The settle counter is cleared on this transition.
- SETTLE:
  - Counts ticks. On the SETTLE_TICKS-th tick, go to IDLE and pulse done.
  - Accel mode: on each tick, resample target_*. If the new target mismatches pos, return to SLEW (no done pulse).
- select_source change mid-SLEW or mid-SETTLE: no abort. It takes effect at the next tick (resample on/off) and in IDLE (handshake vs. sampling).
- mem_valid asserted outside IDLE: ignored, and mem_ready stays 0. The memory source must hold mem_valid and its data until accepted.
- Reset mid-motion: immediate return to HOME_POS, with no slew.
- busy = (state==SLEW) || (state==SETTLE).
- pos_* never leaves [MIN_POS, MAX_POS] after reset, provided HOME_POS is inside the range.
- Arithmetic: use a POS_WIDTH+1 signed diff so subtraction does not wrap.

Optional Feature:
ARM_SEQ_TIMEOUT_EN:
- Defined:
  - A timeout counter counts ticks while in SLEW and clears on entry to SLEW.
  - On reaching TIMEOUT_TICKS: set fault (sticky until reset), set target_* = pos_*, go to IDLE, no done pulse.
- Undefined: no counter, fault tied 0, SLEW is unbounded.

Test Plan:
- Reset check (TICK_DIV=4, STEP=4, SETTLE_TICKS=2, mode 0): release rst -> pos_*=90, mem_ready=1, busy=0, done=0.
- Memory slew: send x=100, y=80, z=90 with mem_valid for 1 cycle -> mem_ready drops next cycle; after 1 tick pos=(94,86,90); after 3 ticks pos=(100,80,90); SETTLE for 2 ticks; one done pulse; mem_ready=1.
- Clamp and hold: send mem_x=500 while busy -> not accepted until IDLE; then accepted, and target_x=180. From 90, pos_x reaches 180 after 23 ticks (last step 2).
- Accel tracking: mode 1, accel=(90,90,90) -> stays IDLE with no done. Step accel_x to 99 -> SLEW; pos_x = 94, 98, 99 on successive ticks. Change accel_x to 50 during SETTLE -> back to SLEW with no done pulse.
- Async reset mid-SLEW: assert rst between ticks -> pos_* = 90 in the same cycle, busy=0.
- With ARM_SEQ_TIMEOUT_EN, TIMEOUT_TICKS=5, STEP=1, target 0 from 90 -> after 5 ticks fault=1, pos_x=85, state IDLE, no done pulse.

Source files
------------

// File: rtl/arm_motion_sequencer.sv
// Picks memory or accelerometer targets and slews pos_* toward them at STEP per tick, then settles.
// Latency: memory target taken the cycle after handshake; position moves once per motion tick.
// Backpressure: mem_ready only in IDLE/memory mode; ARM_SEQ_TIMEOUT_EN adds a sticky SLEW watchdog.
module arm_motion_sequencer #(
    parameter int POS_WIDTH     = 10,
    parameter int TICK_DIV      = 500_000,
    parameter int STEP          = 4,
    parameter int MIN_POS       = 0,
    parameter int MAX_POS       = 180,
    parameter int HOME_POS      = 90,
    parameter int SETTLE_TICKS  = 10,
    parameter int TIMEOUT_TICKS = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 select_source,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [POS_WIDTH-1:0] mem_x,
    input  logic [POS_WIDTH-1:0] mem_y,
    input  logic [POS_WIDTH-1:0] mem_z,
    input  logic [POS_WIDTH-1:0] accel_x,
    input  logic [POS_WIDTH-1:0] accel_y,
    input  logic [POS_WIDTH-1:0] accel_z,
    output logic [POS_WIDTH-1:0] pos_x,
    output logic [POS_WIDTH-1:0] pos_y,
    output logic [POS_WIDTH-1:0] pos_z,
    output logic                 busy,
    output logic                 done,
    output logic                 fault
);

    typedef enum logic [1:0] {S_IDLE, S_SLEW, S_SETTLE} state_t;
    typedef logic [POS_WIDTH-1:0] pos_t;

    localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW  = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
    localparam int PW1 = POS_WIDTH + 1;

    localparam pos_t HOME   = pos_t'(HOME_POS);
    localparam pos_t MIN_P  = pos_t'(MIN_POS);
    localparam pos_t MAX_P  = pos_t'(MAX_POS);
    localparam pos_t STEP_P = pos_t'(STEP);
    localparam logic signed [POS_WIDTH:0] MIN_S  = PW1'(MIN_POS);
    localparam logic signed [POS_WIDTH:0] MAX_S  = PW1'(MAX_POS);
    localparam logic signed [POS_WIDTH:0] STEP_S = PW1'(STEP);

    // Zero-extended signed compares keep the clamp correct for any MIN/MAX.
    function automatic pos_t clamp(input pos_t v);
        if ($signed({1'b0, v}) < MIN_S)
            clamp = MIN_P;
        else if ($signed({1'b0, v}) > MAX_S)
            clamp = MAX_P;
        else
            clamp = v;
    endfunction

    function automatic pos_t step_to(input pos_t p, input pos_t t);
        logic signed [POS_WIDTH:0] diff;
        diff = $signed({1'b0, t}) - $signed({1'b0, p});
        if (diff > STEP_S)
            step_to = p + STEP_P;
        else if (diff < -STEP_S)
            step_to = p - STEP_P;
        else
            step_to = t;
    endfunction

    state_t                      state_q, state_d;
    logic [2:0][POS_WIDTH-1:0]   pos_q, pos_d;
    logic [2:0][POS_WIDTH-1:0]   tgt_q, tgt_d;
    logic [2:0][POS_WIDTH-1:0]   mem_c, accel_c;
    logic [TW-1:0]               cnt_q, cnt_d;
    logic [SW-1:0]               settle_q, settle_d;
    logic                        done_q, done_d;
    logic                        tick;
    logic                        at_tgt;
    logic                        accel_at_pos;

`ifdef ARM_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
    logic [TO_W-1:0] to_q, to_d;
    logic            fault_q, fault_d;
`endif

    always_comb begin
        mem_c[0]   = clamp(mem_x);
        mem_c[1]   = clamp(mem_y);
        mem_c[2]   = clamp(mem_z);
        accel_c[0] = clamp(accel_x);
        accel_c[1] = clamp(accel_y);
        accel_c[2] = clamp(accel_z);
    end

    assign tick         = (cnt_q == TW'(TICK_DIV - 1));
    assign at_tgt       = (pos_q == tgt_q);
    assign accel_at_pos = (accel_c == pos_q);

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        tgt_d    = tgt_q;
        settle_d = settle_q;
        done_d   = 1'b0;
        cnt_d    = tick ? '0 : cnt_q + TW'(1);
`ifdef ARM_SEQ_TIMEOUT_EN
        to_d     = to_q;
        fault_d  = fault_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!select_source) begin
                    if (mem_valid) begin
                        tgt_d   = mem_c;
                        state_d = S_SLEW;
`ifdef ARM_SEQ_TIMEOUT_EN
                        to_d    = '0;
`endif
                    end
                end else if (tick) begin
                    tgt_d = accel_c;
                    if (!accel_at_pos) begin
                        state_d = S_SLEW;
`ifdef ARM_SEQ_TIMEOUT_EN
                        to_d    = '0;
`endif
                    end
                end
            end
            S_SLEW: begin
                // Step toward the target held before this tick; accel resample lands afterwards.
                if (tick) begin
                    for (int i = 0; i < 3; i++)
                        pos_d[i] = step_to(pos_q[i], tgt_q[i]);
                    if (select_source)
                        tgt_d = accel_c;
                end
                if (at_tgt && !(tick && select_source && !accel_at_pos)) begin
                    state_d  = S_SETTLE;
                    settle_d = '0;
                end
`ifdef ARM_SEQ_TIMEOUT_EN
                if (tick && state_d == S_SLEW) begin
                    if (to_q == TO_W'(TIMEOUT_TICKS - 1)) begin
                        fault_d = 1'b1;
                        tgt_d   = pos_d;
                        state_d = S_IDLE;
                    end else begin
                        to_d = to_q + TO_W'(1);
                    end
                end
`endif
            end
            S_SETTLE: begin
                if (tick) begin
                    if (select_source)
                        tgt_d = accel_c;
                    if (select_source && !accel_at_pos) begin
                        state_d = S_SLEW;
`ifdef ARM_SEQ_TIMEOUT_EN
                        to_d    = '0;
`endif
                    end else if (settle_q == SW'(SETTLE_TICKS - 1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        settle_d = settle_q + SW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            pos_q    <= {3{HOME}};
            tgt_q    <= {3{HOME}};
            cnt_q    <= '0;
            settle_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            tgt_q    <= tgt_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            done_q   <= done_d;
        end
    end

`ifdef ARM_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            to_q    <= to_d;
            fault_q <= fault_d;
        end
    end
    assign fault = fault_q;
`else
    // Without the watchdog the limit is meaningless, so fault is a constant 0.
    assign fault = (TIMEOUT_TICKS < 0);
`endif

    assign mem_ready = (state_q == S_IDLE) && !select_source;
    assign busy      = (state_q == S_SLEW) || (state_q == S_SETTLE);
    assign done      = done_q;
    assign pos_x     = pos_q[0];
    assign pos_y     = pos_q[1];
    assign pos_z     = pos_q[2];

endmodule
